// File: rtl/clk_int_div_fpga_pkg.sv
// -----------------------------------------------------------------------------
// clk_int_div_fpga_pkg
// Shared constants and helpers for the integer clock divider.
//   MinDiv    : smallest divide value the divider will run with
//   high_len  : length in source cycles of the high phase for a divide value
// -----------------------------------------------------------------------------
package clk_int_div_fpga_pkg;

    localparam int unsigned MinDiv = 2;

    // ceil(div / 2) without risking overflow when div is all ones.
    function automatic int unsigned high_len(input int unsigned div);
        return (div >> 1) + (div & 32'd1);
    endfunction

endpackage

// File: rtl/tc_clk_mux2.sv
// -----------------------------------------------------------------------------
// tc_clk_mux2
// Generic two-input clock multiplexer. On a real target this is replaced by
// the technology's dedicated glitch-safe clock mux primitive.
//   clk0_i    : clock selected when clk_sel_i = 0
//   clk1_i    : clock selected when clk_sel_i = 1
//   clk_sel_i : select
//   clk_o     : selected clock
// -----------------------------------------------------------------------------
module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);

    assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/clk_int_div_fpga.sv
// -----------------------------------------------------------------------------
// clk_int_div_fpga
// Integer clock divider with a registered (glitch-free) output, a ready/valid
// port for changing the divide value at period boundaries, a boundary-sampled
// enable and a DFT bypass.
//   clk_i       : source clock, all flops on its rising edge
//   rst_i       : asynchronous active-high reset
//   en_i        : divided-clock enable, sampled at period boundaries
//   test_mode_i : bypass, clk_o follows clk_i
//   div_i       : requested divide value (0 and 1 are treated as 2)
//   div_valid_i : div_i is valid
//   div_ready_o : divider can accept a new value
//   tick_o      : high on the last source cycle of every divided period
//   clk_o       : divided clock
// -----------------------------------------------------------------------------
module clk_int_div_fpga
    import clk_int_div_fpga_pkg::*;
#(
    parameter int unsigned DivWidth   = 8,
    parameter int unsigned DefaultDiv = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                test_mode_i,
    input  logic [DivWidth-1:0] div_i,
    input  logic                div_valid_i,
    output logic                div_ready_o,
    output logic                tick_o,
    output logic                clk_o
);

    // Elaboration-time parameter checks.
    if (DivWidth < 2 || DivWidth > 32) begin : g_bad_width
        $error("clk_int_div_fpga: DivWidth must be within 2..32");
    end
    if (DefaultDiv < MinDiv || 64'(DefaultDiv) >= (64'd1 << DivWidth)) begin : g_bad_default
        $error("clk_int_div_fpga: DefaultDiv must be within 2..2^DivWidth-1");
    end

    typedef enum logic [0:0] {
        StRun,
        StPend
    } state_e;

    localparam logic [DivWidth-1:0] ResetDiv = DivWidth'(DefaultDiv);
    localparam logic [DivWidth-1:0] MinDivW  = DivWidth'(MinDiv);
    localparam logic [DivWidth-1:0] One      = DivWidth'(1);

    state_e              state_q, state_d;
    logic [DivWidth-1:0] div_q, div_d;
    logic [DivWidth-1:0] div_pend_q, div_pend_d;
    logic [DivWidth-1:0] cnt_q, cnt_d;
    logic                clk_q, clk_d;
    // Set after a boundary that saw en_i low; the counter is parked at 0.
    logic                gated_q, gated_d;

    logic                at_last;
    logic                boundary;
    logic                high_phase;
    logic [DivWidth-1:0] div_clamped;

    always_comb begin
        at_last     = !gated_q && (cnt_q == div_q - One);
        // While gated every cycle is a boundary, so pending values and the
        // enable are picked up without waiting for a period to elapse.
        boundary    = at_last || gated_q;
        high_phase  = 32'(cnt_q) < high_len(32'(div_q));
        div_clamped = (div_i < MinDivW) ? MinDivW : div_i;
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        div_pend_d = div_pend_q;
        cnt_d      = cnt_q + One;
        gated_d    = gated_q;
        // clk_q is the registered copy of the current phase, so clk_o trails
        // the counter by one cycle and never sees counter decode glitches.
        clk_d      = !gated_q && high_phase;

        case (state_q)
            StRun: begin
                if (div_valid_i) begin
                    div_pend_d = div_clamped;
                    state_d    = StPend;
                end
            end
            StPend: begin
                if (boundary) begin
                    div_d   = div_pend_q;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (boundary) begin
            cnt_d   = '0;
            gated_d = !en_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StRun;
            div_q      <= ResetDiv;
            div_pend_q <= '0;
            cnt_q      <= '0;
            clk_q      <= 1'b0;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            div_pend_q <= div_pend_d;
            cnt_q      <= cnt_d;
            clk_q      <= clk_d;
            gated_q    <= gated_d;
        end
    end

    assign div_ready_o = (state_q == StRun);
    assign tick_o      = at_last;

    tc_clk_mux2 u_clk_mux (
        .clk0_i    (clk_q),
        .clk1_i    (clk_i),
        .clk_sel_i (test_mode_i),
        .clk_o     (clk_o)
    );

endmodule

// File: tb/tb_clk_int_div_fpga.sv
// -----------------------------------------------------------------------------
// tb_clk_int_div_fpga
// Bench for clk_int_div_fpga: directed scenarios followed by random traffic,
// all compared cycle by cycle against a period-level reference model.
// -----------------------------------------------------------------------------
module tb_clk_int_div_fpga;

    localparam int unsigned W      = 8;
    localparam int          DefDiv = 2;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic         test_mode_i;
    logic [W-1:0] div_i;
    logic         div_valid_i;
    logic         div_ready_o;
    logic         tick_o;
    logic         clk_o;

    always #5 clk_i = ~clk_i;

    clk_int_div_fpga #(
        .DivWidth   (W),
        .DefaultDiv (DefDiv)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .test_mode_i (test_mode_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .tick_o      (tick_o),
        .clk_o       (clk_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: position within the current divided period, period
    // length, whether the output is parked, and one pending request.
    int m_div, m_pos, m_pend_val;
    bit m_off, m_pend, m_clk;

    logic last_clk, last_tick, last_rdy;

    function automatic void model_reset();
        m_div      = DefDiv;
        m_pos      = 0;
        m_off      = 1'b0;
        m_pend     = 1'b0;
        m_pend_val = 0;
        m_clk      = 1'b0;
    endfunction

    // Advance the model by one source cycle using the current inputs.
    function automatic void model_advance();
        bit period_end;
        int req;
        period_end = m_off || (m_pos == m_div - 1);
        // Output shows the phase of the cycle just finished.
        m_clk = !m_off && (m_pos < (m_div + 1) / 2);
        if (m_pend && period_end) begin
            m_div  = m_pend_val;
            m_pend = 1'b0;
        end else if (!m_pend && div_valid_i) begin
            req        = int'(div_i);
            m_pend_val = (req < 2) ? 2 : req;
            m_pend     = 1'b1;
        end
        if (period_end) begin
            m_pos = 0;
            m_off = !en_i;
        end else begin
            m_pos = m_pos + 1;
        end
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next
    // falling edge.
    task automatic step();
        #1;
        last_clk  = clk_o;
        last_tick = tick_o;
        last_rdy  = div_ready_o;
        check("tick", tick_o, logic'(!m_off && (m_pos == m_div - 1)));
        check("ready", div_ready_o, logic'(!m_pend));
        check("clk_lo_phase", clk_o, test_mode_i ? 1'b0 : logic'(m_clk));
        model_advance();
        @(posedge clk_i);
        #1;
        if (test_mode_i) check("clk_bypass", clk_o, 1'b1);
        @(negedge clk_i);
    endtask

    task automatic wait_tick(input int lim);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_tick && n < lim);
        check("wait_tick", last_tick, 1'b1);
    endtask

    // Handshake a new divide value, then wait until it has been applied.
    task automatic set_div(input int v);
        int n;
        div_valid_i = 1'b1;
        div_i       = W'(v);
        n           = 0;
        do begin
            step();
            n++;
        end while (!last_rdy && n < 50);
        div_valid_i = 1'b0;
        check("set_div_accept", last_rdy, 1'b1);
        n = 0;
        do begin
            step();
            n++;
        end while (!last_rdy && n < 50);
        check("set_div_apply", last_rdy, 1'b1);
    endtask

    logic [31:0] h_clk, h_tick, h_rdy;
    int          ticks;

    initial begin
        rst_i       = 1'b1;
        en_i        = 1'b1;
        test_mode_i = 1'b0;
        div_i       = '0;
        div_valid_i = 1'b0;
        model_reset();

        // Reset state.
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check("rst_clk", clk_o, 1'b0);
        check("rst_tick", tick_o, 1'b0);
        check("rst_ready", div_ready_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Default divide of 2: toggles every cycle, first high in cycle 1.
        h_clk = '0; h_tick = '0;
        for (int j = 0; j < 6; j++) begin
            step();
            h_clk[j] = last_clk; h_tick[j] = last_tick;
        end
        check_vec("div2_clk", h_clk, 32'b101010);
        check_vec("div2_tick", h_tick, 32'b101010);

        // Value 5 accepted at the first cycle of a divide-by-4 period.
        set_div(4);
        wait_tick(20);
        div_valid_i = 1'b1;
        div_i       = W'(5);
        h_clk = '0; h_tick = '0;
        for (int j = 0; j < 14; j++) begin
            step();
            if (last_rdy) div_valid_i = 1'b0;
            h_clk[j] = last_clk; h_tick[j] = last_tick;
        end
        check_vec("div4to5_clk", h_clk, 32'b01110011100110);
        check_vec("div4to5_tick", h_tick, 32'b10000100001000);

        // Value 0 behaves as 2; ready low only until the boundary.
        div_valid_i = 1'b1;
        div_i       = '0;
        h_rdy = '0; h_tick = '0;
        for (int j = 0; j < 9; j++) begin
            step();
            if (j == 0) div_valid_i = 1'b0;
            h_rdy[j] = last_rdy; h_tick[j] = last_tick;
        end
        check_vec("div0_ready", h_rdy, 32'b111100001);
        check_vec("div0_tick", h_tick, 32'b101010000);

        // Enable dropped at position 1 of a divide-by-6 period.
        set_div(6);
        wait_tick(20);
        h_clk = '0; h_tick = '0;
        for (int j = 0; j < 18; j++) begin
            en_i = (j == 0 || j >= 12);
            step();
            h_clk[j] = last_clk; h_tick[j] = last_tick;
        end
        en_i = 1'b1;
        check_vec("gate_clk", h_clk, 32'b011100000000001110);
        check_vec("gate_tick", h_tick, 32'b000000000000100000);

        // Reset while 9 is pending over a divide-by-4 period.
        set_div(4);
        wait_tick(20);
        div_valid_i = 1'b1;
        div_i       = W'(9);
        step();
        div_valid_i = 1'b0;
        check("pend_clk_high", clk_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check("rst_async_clk", clk_o, 1'b0);
        check("rst_async_ready", div_ready_o, 1'b1);
        check("rst_async_tick", tick_o, 1'b0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        h_clk = '0; h_tick = '0;
        for (int j = 0; j < 8; j++) begin
            step();
            h_clk[j] = last_clk; h_tick[j] = last_tick;
        end
        check_vec("post_rst_clk", h_clk, 32'b10101010);
        check_vec("post_rst_tick", h_tick, 32'b10101010);
        ticks = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (last_tick) ticks++;
        end
        check_vec("post_rst_ticks", 32'(ticks), 32'd10);

        // Bypass mid-period, then back to the divided clock.
        set_div(5);
        for (int j = 0; j < 3; j++) step();
        test_mode_i = 1'b1;
        for (int j = 0; j < 7; j++) step();
        test_mode_i = 1'b0;
        for (int j = 0; j < 10; j++) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            en_i        = ($urandom_range(0, 15) != 0);
            test_mode_i = ($urandom_range(0, 19) == 0);
            if (!div_valid_i && $urandom_range(0, 7) == 0) begin
                div_valid_i = 1'b1;
                div_i       = W'($urandom_range(0, 12));
            end
            step();
            if (div_valid_i && last_rdy) div_valid_i = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
